// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage PC sequencer.
// Provides the controller state encoding, PC width and target alignment.
package pc_fetch_ctrl_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] INSTR_ALIGN = 32'd4;

    // Encoding is visible on the debug state port, so it is fixed.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] a);
        return a & ~(INSTR_ALIGN - 32'd1);
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request handshake.
// Ports: req/addr driven by the fetch controller (master), ready by memory (slave).
interface pc_fetch_if;
    import pc_fetch_ctrl_pkg::*;

    logic            req;
    logic [PC_W-1:0] addr;
    logic            ready;

    modport master (output req, output addr, input ready);
    modport slave  (input req, input addr, output ready);

endinterface

// File: rtl/pc_fetch_ctrl_pc_reg.sv
// Load-enable PC register with asynchronous active-low reset to RESET_VECTOR.
// Ports: clk, rst (active low), load, d (next PC), q (current PC).
module pc_reg
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VECTOR;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC sequencer: owns the PC, drives the imem handshake, arbitrates
// branch/jump/halt/stall, and emits flush strobes plus a sticky fetch timeout.
// Ports: clk, rst (async active low), stall, jump/jump_target,
// branch_taken/branch_target, halt, resume, imem (master), pc, pc_plus4,
// if_valid, flush_ifid, flush_idex, fetch_err, state (debug).
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              WAIT_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt,
    input  logic            resume,
    pc_fetch_if.master      imem,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            if_valid,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            fetch_err,
    output fetch_state_t    state
);

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_TIMEOUT - 1);

    fetch_state_t    next_state;
    logic [7:0]      wait_cnt;
    logic [7:0]      next_wait;
    logic            load;
    logic [PC_W-1:0] pc_d;
    logic            next_valid;
    logic            next_fi;
    logic            next_fe;
    logic            next_err;

    pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (pc_d),
        .q    (pc)
    );

    assign pc_plus4  = pc + INSTR_ALIGN;
    assign imem.req  = (state == FETCH);
    assign imem.addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            wait_cnt   <= 8'd0;
            if_valid   <= 1'b0;
            flush_ifid <= 1'b0;
            flush_idex <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= next_state;
            wait_cnt   <= next_wait;
            if_valid   <= next_valid;
            flush_ifid <= next_fi;
            flush_idex <= next_fe;
            fetch_err  <= next_err;
        end
    end

    always_comb begin
        next_state = state;
        next_wait  = wait_cnt;
        load       = 1'b0;
        pc_d       = pc_plus4;
        next_valid = 1'b0;
        next_fi    = 1'b0;
        next_fe    = 1'b0;
        next_err   = fetch_err;
        unique case (state)
            BOOT: next_state = FETCH;
            FETCH, STALL: begin
                if (branch_taken) begin
                    load       = 1'b1;
                    pc_d       = align(branch_target);
                    next_fi    = 1'b1;
                    next_fe    = 1'b1;
                    next_wait  = 8'd0;
                    next_state = FETCH;
                end else if (jump) begin
                    load       = 1'b1;
                    pc_d       = align(jump_target);
                    next_fi    = 1'b1;
                    next_wait  = 8'd0;
                    next_state = FETCH;
                end else if (halt) begin
                    next_state = HALT;
                end else if (stall) begin
                    next_state = STALL;
                end else if (state == STALL) begin
                    // Fetch restarts; the word is re-requested next cycle.
                    next_state = FETCH;
                end else if (imem.ready) begin
                    load       = 1'b1;
                    next_valid = 1'b1;
                    next_wait  = 8'd0;
                end else begin
                    next_wait = wait_cnt + 8'd1;
                    if (wait_cnt == LAST_WAIT) begin
                        next_err   = 1'b1;
                        next_state = HALT;
                    end
                end
            end
            HALT: begin
                if (resume && !fetch_err) begin
                    next_state = FETCH;
                    next_wait  = 8'd0;
                end
            end
            default: next_state = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random traffic,
// with a per-cycle behavioural model feeding a scoreboard queue.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int WT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0, jump = 1'b0, branch_taken = 1'b0;
    logic halt = 1'b0, resume = 1'b0;
    logic [31:0] jump_target = '0, branch_target = '0;
    logic [31:0] pc, pc_plus4;
    logic if_valid, flush_ifid, flush_idex, fetch_err;
    fetch_state_t state;

    pc_fetch_if bus ();

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .WAIT_TIMEOUT(WT)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .resume        (resume),
        .imem          (bus.master),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .if_valid      (if_valid),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .fetch_err     (fetch_err),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic v, fi, fe, err, req;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 boot, 1 fetching, 2 stalled, 3 halted.
    longint unsigned m_pc;
    int m_mode, m_wait;
    bit m_err, m_v, m_fi, m_fe;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pc = RV; m_mode = 0; m_wait = 0; m_err = 0;
        m_v = 0; m_fi = 0; m_fe = 0;
    endfunction

    function automatic void model_step();
        m_v = 0; m_fi = 0; m_fe = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 3) begin
            if (resume && !m_err) begin m_mode = 1; m_wait = 0; end
        end else if (branch_taken) begin
            m_pc = (longint'(branch_target) / 4) * 4;
            m_fi = 1; m_fe = 1; m_wait = 0; m_mode = 1;
        end else if (jump) begin
            m_pc = (longint'(jump_target) / 4) * 4;
            m_fi = 1; m_wait = 0; m_mode = 1;
        end else if (halt) begin
            m_mode = 3;
        end else if (stall) begin
            m_mode = 2;
        end else if (m_mode == 2) begin
            m_mode = 1;
        end else if (bus.ready) begin
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
            m_v = 1; m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == WT) begin m_err = 1; m_mode = 3; end
        end
    endfunction

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        if (rst) begin
            model_step();
            x.pc = m_pc[31:0]; x.v = m_v; x.fi = m_fi; x.fe = m_fe;
            x.err = m_err; x.req = (m_mode == 1); x.st = 2'(m_mode);
            q.push_back(x);
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_pc"}, pc, RV);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_req"}, 32'(bus.req), 32'd0);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_flush"}, {30'd0, flush_ifid, flush_idex}, 32'd0);
        chk({tag, "_err"}, 32'(fetch_err), 32'd0);
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic hard_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset("async_rst");
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic clear_in();
        stall = 0; jump = 0; branch_taken = 0; halt = 0; resume = 0;
    endtask

    always @(negedge clk) begin
        if (rst && q.size() > 0) begin
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
            chk("imem_addr", bus.addr, e.pc);
            chk("imem_req", 32'(bus.req), 32'(e.req));
            chk("if_valid", 32'(if_valid), 32'(e.v));
            chk("flush_ifid", 32'(flush_ifid), 32'(e.fi));
            chk("flush_idex", 32'(flush_idex), 32'(e.fe));
            chk("fetch_err", 32'(fetch_err), 32'(e.err));
            chk("state", 32'(state), 32'(e.st));
        end
    end

    initial begin
        bus.ready = 1'b1;
        model_reset();
        #3;
        check_reset("por");
        @(negedge clk);
        #2;
        rst = 1'b1;

        // Boot then sequential fetch 0,4,8.
        repeat (3) tick();
        // Branch and jump together at pc=8: branch wins, target aligned.
        branch_taken = 1; branch_target = 32'h43;
        jump = 1; jump_target = 32'h100;
        tick();
        clear_in();
        // Stall at 0x10 with ready held high.
        jump = 1; jump_target = 32'h10;
        tick();
        jump = 0; stall = 1;
        repeat (3) tick();
        stall = 0;
        repeat (2) tick();
        // Halt at 0x20, jumps ignored, resume refetches.
        jump = 1; jump_target = 32'h20;
        tick();
        jump = 0; halt = 1;
        tick();
        halt = 0; jump = 1; jump_target = 32'h80;
        repeat (2) tick();
        jump = 0; resume = 1;
        tick();
        resume = 0;
        repeat (2) tick();
        // Wrap at top of address space, then reset mid-wait.
        jump = 1; jump_target = 32'hFFFF_FFFF;
        tick();
        jump = 0;
        tick();
        bus.ready = 0;
        repeat (3) tick();
        hard_reset();
        // Timeout: boot + 15 waiting fetch cycles, resume ignored.
        repeat (18) tick();
        resume = 1;
        repeat (3) tick();
        resume = 0;
        hard_reset();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = $urandom;
            jump          = ($urandom_range(0, 9) == 0);
            jump_target   = $urandom;
            halt          = ($urandom_range(0, 24) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            bus.ready     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 149) == 0) hard_reset();
            else tick();
        end
        clear_in();
        @(negedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
